// File: rtl/mp_alu_seq_if.sv
// Request/response bus of the multi-byte ALU sequencer.
// The master issues operations and the slave (the sequencer) reports completion.
interface mp_alu_seq_if;
    logic        start;
    logic [1:0]  op;
    logic [1:0]  nbytes;
    logic        use_cin;
    logic        cin_ext;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        c;
    logic        z;

    modport master (
        output start, op, nbytes, use_cin, cin_ext, opa, opb,
        input  busy, done, result, c, z
    );

    modport slave (
        input  start, op, nbytes, use_cin, cin_ext, opa, opb,
        output busy, done, result, c, z
    );
endinterface

// File: rtl/mp_alu_seq.sv
// Multi-byte arithmetic sequencer: walks 1..4 operand bytes through an external
// 8-bit ALU, chaining carry/borrow and accumulating the zero flag.
module mp_alu_seq (
    input  logic             i_clk,
    input  logic             i_rst_n,
    mp_alu_seq_if.slave      bus,
    output logic [3:0]       o_alu_sel,
    output logic [7:0]       o_alu_a,
    output logic [7:0]       o_alu_b,
    output logic             o_alu_cin,
    input  logic [7:0]       i_alu_result,
    input  logic             i_alu_c,
    input  logic             i_alu_z
);
    typedef enum logic [1:0] {StIdle, StExec, StFin} state_e;
    typedef enum logic [1:0] {OpAdd, OpSub, OpCmp, OpAnd} op_e;

    state_e      r_state;
    state_e      w_state_next;
    op_e         r_op;
    logic [1:0]  r_nb;
    logic        r_use_cin;
    logic [31:0] r_opa;
    logic [31:0] r_opb;
    logic [1:0]  r_idx;
    logic        r_carry;
    logic        r_zacc;
    logic [31:0] r_result;
    logic        r_c;
    logic        r_z;
    logic        w_first_plain;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Byte 0 without an external carry uses the carry-less ALU variant.
    assign w_first_plain = (r_idx == 2'd0) && !r_use_cin;

    always_comb begin
        w_state_next = r_state;
        o_alu_sel    = 4'd15;
        o_alu_a      = 8'h00;
        o_alu_b      = 8'h00;
        o_alu_cin    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (bus.start) w_state_next = StExec;
            end
            StExec: begin
                o_alu_a   = r_opa[{r_idx, 3'b000} +: 8];
                o_alu_b   = r_opb[{r_idx, 3'b000} +: 8];
                o_alu_cin = r_carry;
                unique case (r_op)
                    OpAdd:        o_alu_sel = w_first_plain ? 4'd0 : 4'd1;
                    OpSub, OpCmp: o_alu_sel = w_first_plain ? 4'd2 : 4'd3;
                    OpAnd:        o_alu_sel = 4'd5;
                    default:      o_alu_sel = 4'd15;
                endcase
                if (r_idx == r_nb) w_state_next = StFin;
            end
            StFin: begin
                w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_op      <= OpAdd;
            r_nb      <= 2'd0;
            r_use_cin <= 1'b0;
            r_opa     <= 32'h0;
            r_opb     <= 32'h0;
            r_idx     <= 2'd0;
            r_carry   <= 1'b0;
            r_zacc    <= 1'b0;
            r_result  <= 32'h0;
            r_c       <= 1'b0;
            r_z       <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (bus.start) begin
                        r_op      <= op_e'(bus.op);
                        r_nb      <= bus.nbytes;
                        r_use_cin <= bus.use_cin;
                        r_opa     <= bus.opa;
                        r_opb     <= bus.opb;
                        r_idx     <= 2'd0;
                        r_carry   <= bus.use_cin ? bus.cin_ext : 1'b0;
                        r_zacc    <= 1'b1;
                        // CMP reports flags only and leaves the last result visible.
                        if (op_e'(bus.op) != OpCmp) r_result <= 32'h0;
                    end
                end
                StExec: begin
                    if (r_op != OpCmp) r_result[{r_idx, 3'b000} +: 8] <= i_alu_result;
                    r_carry <= i_alu_c;
                    r_zacc  <= r_zacc & i_alu_z;
                    r_idx   <= r_idx + 2'd1;
                end
                StFin: begin
                    r_c <= (r_op == OpAnd) ? 1'b0 : r_carry;
                    r_z <= r_zacc;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = (r_state != StIdle);
    assign bus.done   = (r_state == StFin);
    assign bus.result = r_result;
    assign bus.c      = r_c;
    assign bus.z      = r_z;
endmodule

// File: tb/tb_mp_alu_seq.sv
// Self-checking bench for mp_alu_seq: directed vector table, reset/START-spam
// sequences and randomized operations against a whole-word arithmetic model.
module tb_mp_alu_seq;
    typedef struct {
        logic [1:0]  op;
        logic [1:0]  nb;
        logic        uc;
        logic        ci;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] er;
        logic        ec;
        logic        ez;
        bit          spam;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [3:0]  alu_sel;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic        alu_cin;
    logic [7:0]  alu_result;
    logic        alu_c;
    logic        alu_z;
    int          total;
    int          passed;
    logic [31:0] m_result;

    mp_alu_seq_if bus ();

    mp_alu_seq dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .bus          (bus),
        .o_alu_sel    (alu_sel),
        .o_alu_a      (alu_a),
        .o_alu_b      (alu_b),
        .o_alu_cin    (alu_cin),
        .i_alu_result (alu_result),
        .i_alu_c      (alu_c),
        .i_alu_z      (alu_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External 8-bit ALU.
    always_comb begin
        logic [8:0] s;
        s = 9'd0;
        case (alu_sel)
            4'd0: s = {1'b0, alu_a} + {1'b0, alu_b};
            4'd1: s = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
            4'd2: s = {(alu_a < alu_b), alu_a - alu_b};
            4'd3: s = {({1'b0, alu_a} < ({1'b0, alu_b} + {8'd0, alu_cin})),
                       alu_a - alu_b - {7'd0, alu_cin}};
            4'd5: s = {1'b0, alu_a & alu_b};
            default: s = 9'd0;
        endcase
        alu_result = s[7:0];
        alu_c      = s[8];
        alu_z      = (s[7:0] == 8'd0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Whole-word reference: operands truncated to the selected length.
    function automatic void ref_model(input vec_t v, input logic [31:0] prev,
                                      output logic [31:0] r, output logic c, output logic z);
        longint unsigned mask, a, b, cin, s;
        int n;
        n    = (int'(v.nb) + 1) * 8;
        mask = (64'd1 << n) - 64'd1;
        a    = 64'(v.a) & mask;
        b    = 64'(v.b) & mask;
        cin  = (v.uc && v.ci) ? 64'd1 : 64'd0;
        case (v.op)
            2'd0: begin s = a + b + cin; c = s[n]; end
            2'd1, 2'd2: begin s = a - b - cin; c = (a < b + cin); end
            default: begin s = a & b; c = 1'b0; end
        endcase
        s = s & mask;
        z = (s == 64'd0);
        r = (v.op == 2'd2) ? prev : s[31:0];
    endfunction

    function automatic logic [3:0] exp_sel(input logic [1:0] op, input logic uc, input int j);
        logic [3:0] base;
        case (op)
            2'd0:       base = 4'd0;
            2'd1, 2'd2: base = 4'd2;
            default:    base = 4'd5;
        endcase
        if (op != 2'd3 && (j > 0 || uc)) base = base + 4'd1;
        return base;
    endfunction

    task automatic run_op(input vec_t v);
        int done_cyc, done_cnt, nerr;
        logic [3:0] sels[$];
        logic [7:0] as_q[$], bs_q[$];
        logic       cin0;
        logic [31:0] av, bv;
        sels.delete(); as_q.delete(); bs_q.delete();
        cin0 = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.op = v.op; bus.nbytes = v.nb; bus.use_cin = v.uc;
        bus.cin_ext = v.ci; bus.opa = v.a; bus.opb = v.b;
        @(posedge clk);
        done_cyc = -1;
        done_cnt = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 1 && !v.spam) bus.start = 1'b0;
            if (bus.done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = i;
                chk("fin_alu_idle", {alu_sel, alu_a, alu_b, 3'd0, alu_cin}, {4'hf, 20'd0});
            end else if (bus.busy) begin
                if (sels.size() == 0) cin0 = alu_cin;
                sels.push_back(alu_sel);
                as_q.push_back(alu_a);
                bs_q.push_back(alu_b);
            end
            if (done_cyc >= 0 && i == done_cyc + 1) begin
                chk("result", bus.result, v.er);
                chk("c_flag", {31'd0, bus.c}, {31'd0, v.ec});
                chk("z_flag", {31'd0, bus.z}, {31'd0, v.ez});
                chk("busy_after", {31'd0, bus.busy}, 32'd0);
                chk("idle_alu", {alu_sel, alu_a, alu_b, 3'd0, alu_cin}, {4'hf, 20'd0});
            end
            if (v.spam && done_cyc >= 0 && i > done_cyc) bus.start = 1'b0;
            if (done_cyc >= 0 && i >= done_cyc + 3) break;
        end
        bus.start = 1'b0;
        chk("latency", done_cyc, int'(v.nb) + 2);
        chk("done_count", done_cnt, 1);
        chk("exec_cycles", sels.size(), int'(v.nb) + 1);
        nerr = 0;
        av = v.a;
        bv = v.b;
        for (int j = 0; j < sels.size(); j++) begin
            if (sels[j] !== exp_sel(v.op, v.uc, j)) nerr++;
            if (as_q[j] !== av[j*8 +: 8] || bs_q[j] !== bv[j*8 +: 8]) nerr++;
        end
        if (cin0 !== (v.uc & v.ci)) nerr++;
        chk("alu_drive_errors", nerr, 0);
        m_result = v.er;
    endtask

    vec_t vt[8];

    initial begin
        vec_t v;
        logic [31:0] r;
        logic c, z;
        int dcnt;
        total = 0; passed = 0; m_result = 32'h0;
        bus.start = 1'b0; bus.op = 2'd0; bus.nbytes = 2'd0; bus.use_cin = 1'b0;
        bus.cin_ext = 1'b0; bus.opa = 32'h0; bus.opb = 32'h0;
        rst_n = 1'b0;

        //        op    nb    uc    ci    a             b             result        c     z     spam
        vt[0] = '{2'd0, 2'd3, 1'b0, 1'b0, 32'h00FFFFFF, 32'h00000001, 32'h01000000, 1'b0, 1'b0, 1'b0};
        vt[1] = '{2'd0, 2'd1, 1'b0, 1'b0, 32'h0000FFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b0};
        vt[2] = '{2'd1, 2'd0, 1'b0, 1'b0, 32'h00000000, 32'h00000001, 32'h000000FF, 1'b1, 1'b0, 1'b0};
        vt[3] = '{2'd0, 2'd0, 1'b1, 1'b1, 32'h00000001, 32'h00000001, 32'h00000003, 1'b0, 1'b0, 1'b0};
        vt[4] = '{2'd0, 2'd3, 1'b0, 1'b0, 32'hA5A5A5A5, 32'h00000000, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b0};
        vt[5] = '{2'd2, 2'd3, 1'b0, 1'b0, 32'h12345678, 32'h12345678, 32'hA5A5A5A5, 1'b0, 1'b1, 1'b0};
        vt[6] = '{2'd3, 2'd3, 1'b0, 1'b0, 32'hF0F0FFFF, 32'h0FF01234, 32'h00F01234, 1'b0, 1'b0, 1'b1};
        vt[7] = '{2'd1, 2'd1, 1'b1, 1'b1, 32'hFFFF0000, 32'h00000000, 32'h0000FFFF, 1'b1, 1'b0, 1'b1};

        #3;
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_outputs", {bus.result[27:0], bus.c, bus.z, 2'b00}, 32'd0);
        chk("rst_alu", {alu_sel, alu_a, alu_b, 3'd0, alu_cin}, {4'hf, 20'd0});
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 8; k++) run_op(vt[k]);

        // Reset asserted while byte 2 is on the ALU.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'd0; bus.nbytes = 2'd3; bus.use_cin = 1'b0;
        bus.opa = 32'h11223344; bus.opb = 32'h01010101;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
        chk("pre_rst_sel", {28'd0, alu_sel}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_state", {bus.busy, bus.done, bus.c, bus.z, 28'd0}, 32'd0);
        chk("mid_rst_result", bus.result, 32'h0);
        chk("mid_rst_alu", {alu_sel, alu_a, alu_b, 3'd0, alu_cin}, {4'hf, 20'd0});
        @(negedge clk);
        rst_n = 1'b1;
        m_result = 32'h0;
        dcnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.done) dcnt++;
        end
        chk("no_done_after_abort", dcnt, 0);

        // Randomized operations against the reference model.
        for (int k = 0; k < 40; k++) begin
            v.op = 2'($urandom_range(0, 3));
            v.nb = 2'($urandom_range(0, 3));
            v.uc = 1'($urandom_range(0, 1));
            v.ci = 1'($urandom_range(0, 1));
            v.a = $urandom;
            v.b = (k % 5 == 0) ? v.a : $urandom;
            v.spam = (k % 7 == 3);
            ref_model(v, m_result, r, c, z);
            v.er = r; v.ec = c; v.ez = z;
            run_op(v);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
